// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus responder: FSM state codes, op encoding
// and the default number of wait states.
package mem_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam int WAIT_CYCLES_DEFAULT = 2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_word_array.sv
// Word storage for the bus responder: synchronous write, registered read.
// Contents are never reset; only the read register is.
module mem_word_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    // Read register holds its value until the next enabled read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (en && !we) begin
            rdata_reg <= mem[idx];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_bus_responder.sv
// Wait-state memory responder: IDLE -> BUSY (WAIT_CYCLES) -> RESP with a one-cycle ready.
// Define MEM_MISALIGN_CHECK_EN to flag accesses with addr[1:0] != 0 as bus errors.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        bus_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t        state_reg, state_next;
    logic [3:0]    count_reg, count_next;
    logic [AW-1:0] idx_reg;
    logic [31:0]   wdata_reg;
    logic          op_reg;
    logic          err_reg;

    logic          req;
    logic          misalign;
    logic          req_err;
    logic          in_idle;
    logic          acc_fire;
    logic          acc_op;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          arr_en;
    logic          arr_we;
    logic          unused_addr_bits;

    assign req = mem_read | mem_write;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = (addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign req_err          = (mem_read & mem_write) | misalign;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = BUSY;
                        count_next = WAIT_INIT;
                    end
                end
            end
            BUSY: begin
                count_next = count_reg - 4'd1;
                if (count_reg <= 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The array is accessed on the edge entering RESP; with no wait states that
    // edge is the sampling edge itself, so the live request is used directly.
    assign in_idle   = (state_reg == IDLE);
    assign acc_fire  = (state_next == RESP) && (state_reg != RESP);
    assign acc_idx   = in_idle ? addr[AW+1:2] : idx_reg;
    assign acc_op    = in_idle ? (mem_write ? OP_WRITE : OP_READ) : op_reg;
    assign acc_err   = in_idle ? req_err : err_reg;
    assign acc_wdata = in_idle ? wdata : wdata_reg;
    assign arr_en    = acc_fire & ~acc_err;
    assign arr_we    = arr_en & (acc_op == OP_WRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            op_reg    <= OP_READ;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (in_idle && req) begin
                idx_reg   <= addr[AW+1:2];
                wdata_reg <= wdata;
                op_reg    <= mem_write ? OP_WRITE : OP_READ;
                err_reg   <= req_err;
            end
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (arr_en),
        .we    (arr_we),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (rdata)
    );

    assign ready   = (state_reg == RESP);
    assign bus_err = ready & err_reg;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with two wait states, one with none.
// Expected responses are queued when a request is driven and checked when ready pulses.
module tb_mem_bus_responder;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rd2, wr2, ready2, err2;
    logic [31:0] addr2, wdata2, rdata2;
    logic        rd0, wr0, ready0, err0;
    logic [31:0] addr0, wdata0, rdata0;

    mem_bus_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .mem_read(rd2), .mem_write(wr2), .addr(addr2),
        .wdata(wdata2), .rdata(rdata2), .ready(ready2), .bus_err(err2)
    );

    mem_bus_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_read(rd0), .mem_write(wr0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .ready(ready0), .bus_err(err0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          issue;
        int          lat;
        int          id;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", what, act, req, $time);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
        end else begin
            rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d;
        end
    endtask

    // Called on a falling edge: pops and compares on ready, else bus_err must be low.
    task automatic observe(input int sel, output logic seen);
        logic        rdy, be;
        logic [31:0] rdv;
        exp_t        e;
        rdy  = (sel == 0) ? ready0 : ready2;
        be   = (sel == 0) ? err0   : err2;
        rdv  = (sel == 0) ? rdata0 : rdata2;
        seen = rdy;
        if (rdy) begin
            if (sb.size() == 0) begin
                check("pending_txn", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("bus_err", {31'd0, be}, {31'd0, e.err});
                check("rdata", rdv, e.rdata);
                check("latency", 32'(cyc - e.issue), 32'(e.lat));
                $display("txn %0d dut_wait=%0d bus_err=%0b rdata=%h latency=%0d",
                         e.id, sel, be, rdv, cyc - e.issue);
            end
        end else begin
            check("bus_err_idle", {31'd0, be}, 32'd0);
        end
    endtask

    task automatic run_txn(input int sel, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic exp_err, input logic [31:0] exp_rd,
                           input int id, input bit mutate);
        exp_t e;
        logic seen;
        e.err   = exp_err;
        e.rdata = exp_rd;
        e.issue = cyc;
        e.lat   = (sel == 0) ? 1 : 3;
        e.id    = id;
        drive(sel, rd, wr, a, d);
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (mutate && k == 0) drive(sel, 1'b0, 1'b1, 32'h20, 32'hBADBAD00);
            observe(sel, seen);
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        if (!seen) begin
            check("ready_timeout", {31'd0, seen}, 32'd1);
            sb.delete();
        end
        @(negedge clk);
        observe(sel, seen);
    endtask

    task automatic run_held(input int sel, input logic [31:0] a,
                            input logic [31:0] exp_rd, input int pulses);
        int   lat, gap, base, got;
        logic seen;
        exp_t e;
        lat  = (sel == 0) ? 1 : 3;
        gap  = lat + 1;
        base = cyc;
        for (int p = 0; p < pulses; p++) begin
            e.err = 1'b0; e.rdata = exp_rd; e.issue = base + p * gap; e.lat = lat; e.id = 100 + p;
            sb.push_back(e);
        end
        drive(sel, 1'b1, 1'b0, a, 32'h0);
        got = 0;
        for (int k = 1; k < pulses * gap; k++) begin
            @(negedge clk);
            observe(sel, seen);
            if (seen) got++;
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        check("held_pulses", 32'(got), 32'(pulses));
        sb.delete();
        @(negedge clk);
        observe(sel, seen);
    endtask

    initial begin
        logic seen;
        vecs[0]  = '{rd:1'b0, wr:1'b1, addr:32'h10,   wdata:32'hDEADBEEF, exp_err:1'b0, exp_rdata:32'h0};
        vecs[1]  = '{rd:1'b1, wr:1'b0, addr:32'h10,   wdata:32'h0,        exp_err:1'b0, exp_rdata:32'hDEADBEEF};
        vecs[2]  = '{rd:1'b0, wr:1'b1, addr:32'h20,   wdata:32'h11112222, exp_err:1'b0, exp_rdata:32'hDEADBEEF};
        vecs[3]  = '{rd:1'b1, wr:1'b1, addr:32'h20,   wdata:32'h00000BAD, exp_err:1'b1, exp_rdata:32'hDEADBEEF};
        vecs[4]  = '{rd:1'b1, wr:1'b0, addr:32'h20,   wdata:32'h0,        exp_err:1'b0, exp_rdata:32'h11112222};
        vecs[5]  = '{rd:1'b0, wr:1'b1, addr:32'h4,    wdata:32'hA5A5A5A5, exp_err:1'b0, exp_rdata:32'h11112222};
        vecs[6]  = '{rd:1'b1, wr:1'b0, addr:32'h6,    wdata:32'h0,        exp_err:MISALIGN_EN,
                     exp_rdata:(MISALIGN_EN ? 32'h11112222 : 32'hA5A5A5A5)};
        vecs[7]  = '{rd:1'b0, wr:1'b1, addr:32'h1008, wdata:32'h55,       exp_err:1'b0,
                     exp_rdata:(MISALIGN_EN ? 32'h11112222 : 32'hA5A5A5A5)};
        vecs[8]  = '{rd:1'b1, wr:1'b0, addr:32'h8,    wdata:32'h0,        exp_err:1'b0, exp_rdata:32'h55};
        vecs[9]  = '{rd:1'b1, wr:1'b0, addr:32'h4,    wdata:32'h0,        exp_err:1'b0, exp_rdata:32'hA5A5A5A5};
        vecs[10] = '{rd:1'b0, wr:1'b1, addr:32'h30,   wdata:32'h30303030, exp_err:1'b0, exp_rdata:32'hA5A5A5A5};
        vecs[11] = '{rd:1'b1, wr:1'b0, addr:32'h30,   wdata:32'h0,        exp_err:1'b0, exp_rdata:32'h30303030};
        vecs[12] = '{rd:1'b0, wr:1'b1, addr:32'hFFC,  wdata:32'hCAFEF00D, exp_err:1'b0, exp_rdata:32'h30303030};
        vecs[13] = '{rd:1'b1, wr:1'b0, addr:32'h7FFC, wdata:32'h0,        exp_err:1'b0, exp_rdata:32'hCAFEF00D};
        vecs[14] = '{rd:1'b0, wr:1'b1, addr:32'h13,   wdata:32'h99,       exp_err:MISALIGN_EN, exp_rdata:32'hCAFEF00D};
        vecs[15] = '{rd:1'b1, wr:1'b0, addr:32'h10,   wdata:32'h0,        exp_err:1'b0,
                     exp_rdata:(MISALIGN_EN ? 32'hDEADBEEF : 32'h99)};

        reset = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("reset_rdata2", rdata2, 32'h0);
        check("reset_ready2", {31'd0, ready2}, 32'd0);
        check("reset_err2", {31'd0, err2}, 32'd0);
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_ready0", {31'd0, ready0}, 32'd0);
        check("reset_err0", {31'd0, err0}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_txn(2, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_err, vecs[i].exp_rdata, i, 1'b0);
        end

        // Inputs change to a write of 0x20 during BUSY: the read of 0x8 must complete untouched.
        run_txn(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h55, 20, 1'b1);
        run_txn(2, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11112222, 21, 1'b0);
        run_held(2, 32'h30, 32'h30303030, 2);

        // Reset during BUSY of a write to 0x30 aborts it.
        drive(2, 1'b0, 1'b1, 32'h30, 32'hDEAD0030);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("abort_rdata2", rdata2, 32'h0);
        check("abort_ready2", {31'd0, ready2}, 32'd0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            observe(2, seen);
        end
        run_txn(2, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h30303030, 30, 1'b0);

        run_txn(0, 1'b0, 1'b1, 32'h48, 32'h55, 1'b0, 32'h0, 40, 1'b0);
        run_txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h55, 41, 1'b0);
        run_txn(0, 1'b1, 1'b1, 32'h8, 32'h77, 1'b1, 32'h55, 42, 1'b0);
        run_txn(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h55, 43, 1'b0);
        run_held(0, 32'h8, 32'h55, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
